// File: rtl/fifo_read_scheduler.sv
// fifo_read_scheduler: shares the out_fifo write port between N FWFT source FIFOs (src0 = TLU, 1..N-1 = FE).
// Optional build macro SCHED_STATS_EN adds STAT_CLEAR / STAT_COUNT per-source word counters.
module fifo_read_scheduler #(
    parameter int N         = 5,
    parameter int BURST_LEN = 16
) (
    input  logic              BUS_CLK,
    input  logic              BUS_RST,
    input  logic [N-1:0]      SRC_EMPTY,
    input  logic [32*N-1:0]   SRC_DATA,
    output logic [N-1:0]      SRC_READ,
    input  logic [N-1:0]      SRC_ENABLE,
    input  logic              PREEMPT_REQ,
    input  logic              OUT_READ_NEXT,
    output logic              OUT_EMPTY,
    output logic [31:0]       OUT_DATA,
    output logic [N-1:0]      GRANT,
`ifdef SCHED_STATS_EN
    input  logic              STAT_CLEAR,
    output logic [16*N-1:0]   STAT_COUNT,
`endif
    output logic              READ_ERR
);
    localparam int PW = $clog2(N);
    localparam int SW = PW + 1;
    localparam logic [PW-1:0] RR_FIRST = PW'(1);
    localparam logic [PW-1:0] RR_LAST  = PW'(N - 1);
    localparam logic [N-1:0]  GRANT_SRC0 = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t        state_r, state_s;
    logic [N-1:0]  grant_r, grant_s;
    logic [7:0]    burst_cnt_r, burst_cnt_s;
    logic [PW-1:0] rr_ptr_r, rr_ptr_s;
    logic          read_err_r;
    logic [N-1:0]  elig_s;
    logic          xfer_s;
    logic [PW-1:0] fe_pick_s, cand_s;
    logic [SW-1:0] sum_s;
    logic          fe_found_s;

    assign elig_s    = ~SRC_EMPTY & SRC_ENABLE;
    assign OUT_EMPTY = ~|(grant_r & elig_s);
    assign xfer_s    = OUT_READ_NEXT & ~OUT_EMPTY;
    assign SRC_READ  = grant_r & {N{xfer_s}};
    assign GRANT     = grant_r;
    assign READ_ERR  = read_err_r;

    // Output data mux: zero when nothing is granted.
    always_comb begin
        OUT_DATA = 32'h0000_0000;
        for (int i = 0; i < N; i++) begin
            if (grant_r[i]) begin
                OUT_DATA = OUT_DATA | SRC_DATA[32*i +: 32];
            end else begin
                OUT_DATA = OUT_DATA;
            end
        end
    end

    // Round-robin search over FE sources, starting at the pointer and wrapping N-1 -> 1.
    always_comb begin
        fe_pick_s  = RR_FIRST;
        fe_found_s = 1'b0;
        sum_s      = '0;
        cand_s     = RR_FIRST;
        for (int k = 0; k < N - 1; k++) begin
            sum_s = {1'b0, rr_ptr_r} + SW'(k);
            if (sum_s >= SW'(N)) begin
                cand_s = PW'(sum_s - SW'(N - 1));
            end else begin
                cand_s = PW'(sum_s);
            end
            if (!fe_found_s && elig_s[cand_s]) begin
                fe_found_s = 1'b1;
                fe_pick_s  = cand_s;
            end else begin
                fe_found_s = fe_found_s;
            end
        end
    end

    // Next-state logic: grant selection in IDLE, burst accounting and release in BUSY.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        burst_cnt_s = burst_cnt_r;
        rr_ptr_s    = rr_ptr_r;
        case (state_r)
            ST_IDLE: begin
                burst_cnt_s = 8'd0;
                if (elig_s[0]) begin
                    grant_s = GRANT_SRC0;
                    state_s = ST_BUSY;
                end else if (fe_found_s) begin
                    grant_s  = GRANT_SRC0 << fe_pick_s;
                    rr_ptr_s = (fe_pick_s == RR_LAST) ? RR_FIRST : fe_pick_s + RR_FIRST;
                    state_s  = ST_BUSY;
                end else begin
                    grant_s = '0;
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                burst_cnt_s = burst_cnt_r + {7'd0, xfer_s};
                // Preemption and burst limit only apply to FE grants; the TLU is held until empty.
                if (OUT_EMPTY) begin
                    grant_s = '0;
                    state_s = ST_IDLE;
                end else if (!grant_r[0] &&
                             ((burst_cnt_s == 8'(BURST_LEN)) || (PREEMPT_REQ && elig_s[0]))) begin
                    grant_s = '0;
                    state_s = ST_IDLE;
                end else begin
                    grant_s = grant_r;
                    state_s = ST_BUSY;
                end
            end
            default: begin
                grant_s = '0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, grant, burst counter, RR pointer and read-error registers.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_r     <= ST_IDLE;
            grant_r     <= '0;
            burst_cnt_r <= 8'd0;
            rr_ptr_r    <= RR_FIRST;
            read_err_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            grant_r     <= grant_s;
            burst_cnt_r <= burst_cnt_s;
            rr_ptr_r    <= rr_ptr_s;
            read_err_r  <= OUT_READ_NEXT & OUT_EMPTY;
        end
    end

`ifdef SCHED_STATS_EN
    logic [16*N-1:0] stat_cnt_r;

    // Saturating per-source word counters; clear wins over a coincident read.
    always_ff @(posedge BUS_CLK) begin
        for (int i = 0; i < N; i++) begin
            if (BUS_RST || STAT_CLEAR) begin
                stat_cnt_r[16*i +: 16] <= 16'h0000;
            end else if (SRC_READ[i] && (stat_cnt_r[16*i +: 16] != 16'hFFFF)) begin
                stat_cnt_r[16*i +: 16] <= stat_cnt_r[16*i +: 16] + 16'd1;
            end else begin
                stat_cnt_r[16*i +: 16] <= stat_cnt_r[16*i +: 16];
            end
        end
    end

    assign STAT_COUNT = stat_cnt_r;
`endif

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Scoreboard bench for fifo_read_scheduler: modelled FWFT sources, expected words queued in grant order.
module tb_fifo_read_scheduler;
    localparam int N = 5;

    logic            BUS_CLK = 1'b0;
    logic            BUS_RST;
    logic [N-1:0]    SRC_EMPTY;
    logic [32*N-1:0] SRC_DATA;
    logic [N-1:0]    SRC_READ;
    logic [N-1:0]    SRC_ENABLE;
    logic            PREEMPT_REQ;
    logic            OUT_READ_NEXT;
    logic            OUT_EMPTY;
    logic [31:0]     OUT_DATA;
    logic [N-1:0]    GRANT;
    logic            READ_ERR;
`ifdef SCHED_STATS_EN
    logic            STAT_CLEAR;
    logic [16*N-1:0] STAT_COUNT;
`endif

    always #5 BUS_CLK = ~BUS_CLK;

    fifo_read_scheduler #(.N(N), .BURST_LEN(16)) dut (
        .BUS_CLK       (BUS_CLK),
        .BUS_RST       (BUS_RST),
        .SRC_EMPTY     (SRC_EMPTY),
        .SRC_DATA      (SRC_DATA),
        .SRC_READ      (SRC_READ),
        .SRC_ENABLE    (SRC_ENABLE),
        .PREEMPT_REQ   (PREEMPT_REQ),
        .OUT_READ_NEXT (OUT_READ_NEXT),
        .OUT_EMPTY     (OUT_EMPTY),
        .OUT_DATA      (OUT_DATA),
        .GRANT         (GRANT),
`ifdef SCHED_STATS_EN
        .STAT_CLEAR    (STAT_CLEAR),
        .STAT_COUNT    (STAT_COUNT),
`endif
        .READ_ERR      (READ_ERR)
    );

    int rem [N];
    int seq [N];
    int read_cnt [N];
    logic [31:0]  exp_q [$];
    logic [N-1:0] grant_log [$];
    int           burst_log [$];
    int           gap_log [$];
    logic [N-1:0] prev_grant;
    int cur_burst, gap_cnt;
    int n_checks, n_fail;
    bit sb_en;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int s, input int k);
        return {8'(s), 24'(k)};
    endfunction

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            SRC_EMPTY[i] = (rem[i] == 0);
            SRC_DATA[32*i +: 32] = word_of(i, seq[i]);
        end
    endtask

    task automatic push_exp(input int s, input int first, input int cnt);
        for (int k = 0; k < cnt; k++) exp_q.push_back(word_of(s, first + k));
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; seq[i] = 0; read_cnt[i] = 0;
        end
        exp_q.delete(); grant_log.delete(); burst_log.delete(); gap_log.delete();
        prev_grant = '0; cur_burst = 0; gap_cnt = 0;
        drive_sources();
    endtask

    // One clock: sample at negedge, score any read, then pop the model FIFOs after the edge.
    task automatic step();
        logic [N-1:0] rd;
        @(negedge BUS_CLK);
        rd = SRC_READ;
        if (GRANT != '0 && prev_grant == '0) begin
            grant_log.push_back(GRANT);
            gap_log.push_back(gap_cnt);
            gap_cnt = 0;
        end
        if (GRANT == '0 && prev_grant != '0) begin
            burst_log.push_back(cur_burst);
            cur_burst = 0;
        end
        if (GRANT == '0) gap_cnt++;
        if (rd != '0) begin
            cur_burst++;
            check_eq("rd_onehot", 32'($onehot(rd)), 32'd1);
            if (sb_en) begin
                if (exp_q.size() == 0) check_eq("sb_extra_read", 32'(rd), 32'd0);
                else check_eq("out_data", OUT_DATA, exp_q.pop_front());
            end
        end
        prev_grant = GRANT;
        @(posedge BUS_CLK);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rd[i]) begin
                read_cnt[i]++;
                if (rem[i] > 0) begin
                    rem[i]--;
                    seq[i]++;
                end
            end
        end
        drive_sources();
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || GRANT != '0) && cyc < max_cyc) begin
            step();
            cyc++;
        end
        check_eq({tag, "_drained"}, 32'(cyc < max_cyc), 32'd1);
        repeat (2) step();
    endtask

    task automatic do_reset();
        OUT_READ_NEXT = 1'b0;
        BUS_RST = 1'b1;
        @(posedge BUS_CLK);
        @(posedge BUS_CLK);
        #1;
        BUS_RST = 1'b0;
        clear_model();
    endtask

    initial begin
        int cyc;
        bit fired;
        n_checks = 0; n_fail = 0; sb_en = 1'b1;
        BUS_RST = 1'b1; PREEMPT_REQ = 1'b0; OUT_READ_NEXT = 1'b1;
        SRC_ENABLE = '1; SRC_DATA = '0; SRC_EMPTY = '1;
`ifdef SCHED_STATS_EN
        STAT_CLEAR = 1'b0;
`endif
        // Reset state: src1 has data and a read is requested, yet everything stays idle.
        clear_model();
        rem[1] = 5;
        drive_sources();
        repeat (3) @(posedge BUS_CLK);
        @(negedge BUS_CLK);
        check_eq("rst_grant", 32'(GRANT), 32'd0);
        check_eq("rst_read_err", 32'(READ_ERR), 32'd0);
        check_eq("rst_out_empty", 32'(OUT_EMPTY), 32'd1);
        check_eq("rst_src_read", 32'(SRC_READ), 32'd0);
        check_eq("rst_out_data", OUT_DATA, 32'd0);
        @(posedge BUS_CLK);
        #1;
        BUS_RST = 1'b0;
        push_exp(1, 0, 5);
        drain("t0", 50);
        check_eq("t0_first_grant", 32'(grant_log[0]), 32'h2);

        // Test 1: single FE source with 40 words -> bursts 16,16,8 with one idle cycle between.
        do_reset();
        rem[2] = 40;
        drive_sources();
        push_exp(2, 0, 40);
        OUT_READ_NEXT = 1'b1;
        drain("t1", 200);
        check_eq("t1_nbursts", 32'(burst_log.size()), 32'd3);
        check_eq("t1_burst0", 32'(burst_log[0]), 32'd16);
        check_eq("t1_burst1", 32'(burst_log[1]), 32'd16);
        check_eq("t1_burst2", 32'(burst_log[2]), 32'd8);
        check_eq("t1_gap1", 32'(gap_log[1]), 32'd1);
        check_eq("t1_gap2", 32'(gap_log[2]), 32'd1);

        // Test 2: four FE sources with 20 words each -> round-robin 1,2,3,4,1,2,3,4.
        do_reset();
        for (int s = 1; s < N; s++) rem[s] = 20;
        drive_sources();
        for (int s = 1; s < N; s++) push_exp(s, 0, 16);
        for (int s = 1; s < N; s++) push_exp(s, 16, 4);
        OUT_READ_NEXT = 1'b1;
        drain("t2", 400);
        check_eq("t2_ngrants", 32'(grant_log.size()), 32'd8);
        for (int j = 0; j < 8; j++) check_eq("t2_grant_order", 32'(grant_log[j]), 32'(1 << (1 + j % 4)));

        // Test 3: TLU preempts src3 after its 6th word; src4 follows the TLU, then src3 resumes.
        do_reset();
        rem[3] = 10; rem[4] = 2;
        drive_sources();
        push_exp(3, 0, 6); push_exp(0, 0, 3); push_exp(4, 0, 2); push_exp(3, 6, 4);
        OUT_READ_NEXT = 1'b1;
        fired = 1'b0;
        cyc = 0;
        while ((exp_q.size() != 0 || GRANT != '0) && cyc < 200) begin
            step();
            cyc++;
            if (!fired && read_cnt[3] == 5) begin
                fired = 1'b1;
                PREEMPT_REQ = 1'b1;
                rem[0] = 3;
                drive_sources();
            end
        end
        check_eq("t3_drained", 32'(cyc < 200), 32'd1);
        repeat (2) step();
        PREEMPT_REQ = 1'b0;
        check_eq("t3_ngrants", 32'(grant_log.size()), 32'd4);
        check_eq("t3_grant0", 32'(grant_log[0]), 32'h08);
        check_eq("t3_grant1", 32'(grant_log[1]), 32'h01);
        check_eq("t3_grant2", 32'(grant_log[2]), 32'h10);
        check_eq("t3_grant3", 32'(grant_log[3]), 32'h08);

        // Test 4: read request with every source empty -> no strobe, READ_ERR for one cycle.
        do_reset();
        OUT_READ_NEXT = 1'b1;
        @(negedge BUS_CLK);
        check_eq("t4_err_before", 32'(READ_ERR), 32'd0);
        check_eq("t4_src_read", 32'(SRC_READ), 32'd0);
        check_eq("t4_out_empty", 32'(OUT_EMPTY), 32'd1);
        @(posedge BUS_CLK);
        #1;
        OUT_READ_NEXT = 1'b0;
        @(negedge BUS_CLK);
        check_eq("t4_err_pulse", 32'(READ_ERR), 32'd1);
        @(negedge BUS_CLK);
        check_eq("t4_err_after", 32'(READ_ERR), 32'd0);

        // Test 5: reset after word 7 of a src1 burst; afterwards the RR search restarts at src1.
        do_reset();
        rem[1] = 20; rem[2] = 5;
        drive_sources();
        push_exp(1, 0, 7);
        OUT_READ_NEXT = 1'b1;
        cyc = 0;
        while (read_cnt[1] < 7 && cyc < 100) begin
            step();
            cyc++;
        end
        check_eq("t5_reached_word7", 32'(read_cnt[1]), 32'd7);
        BUS_RST = 1'b1;
        OUT_READ_NEXT = 1'b0;
        @(posedge BUS_CLK);
        @(negedge BUS_CLK);
        check_eq("t5_grant_rst", 32'(GRANT), 32'd0);
        check_eq("t5_empty_rst", 32'(OUT_EMPTY), 32'd1);
        push_exp(1, 7, 13); push_exp(2, 0, 5);
        grant_log.delete();
        prev_grant = '0;
        @(posedge BUS_CLK);
        #1;
        BUS_RST = 1'b0;
        OUT_READ_NEXT = 1'b1;
        drain("t5", 200);
        check_eq("t5_first_grant", 32'(grant_log[0]), 32'h02);
        check_eq("t5_second_grant", 32'(grant_log[1]), 32'h04);

        // Test 6: grant latency and SRC_ENABLE dropped mid-burst.
        do_reset();
        rem[1] = 10;
        drive_sources();
        @(negedge BUS_CLK);
        check_eq("t6_lat_cycle0", 32'(GRANT), 32'd0);
        @(posedge BUS_CLK);
        #1;
        @(negedge BUS_CLK);
        check_eq("t6_lat_cycle1", 32'(GRANT), 32'h02);
        check_eq("t6_fwft_data", OUT_DATA, word_of(1, 0));
        push_exp(1, 0, 10);
        prev_grant = GRANT;
        @(posedge BUS_CLK);
        #1;
        OUT_READ_NEXT = 1'b1;
        cyc = 0;
        while (read_cnt[1] < 3 && cyc < 50) begin
            step();
            cyc++;
        end
        SRC_ENABLE[1] = 1'b0;
        @(negedge BUS_CLK);
        check_eq("t6_dis_no_read", 32'(SRC_READ), 32'd0);
        check_eq("t6_dis_empty", 32'(OUT_EMPTY), 32'd1);
        @(negedge BUS_CLK);
        check_eq("t6_dis_released", 32'(GRANT), 32'd0);
        prev_grant = '0;
        @(posedge BUS_CLK);
        #1;
        SRC_ENABLE = '1;
        drain("t6", 100);

`ifdef SCHED_STATS_EN
        // Test 7: statistics counting, clearing and saturation.
        do_reset();
        rem[2] = 100;
        drive_sources();
        push_exp(2, 0, 100);
        OUT_READ_NEXT = 1'b1;
        drain("t7", 400);
        check_eq("t7_count100", 32'(STAT_COUNT[47:32]), 32'd100);
        STAT_CLEAR = 1'b1;
        @(posedge BUS_CLK);
        #1;
        STAT_CLEAR = 1'b0;
        @(negedge BUS_CLK);
        check_eq("t7_cleared", 32'(STAT_COUNT[47:32]), 32'd0);
        sb_en = 1'b0;
        rem[0] = 65540;
        drive_sources();
        cyc = 0;
        while (rem[0] != 0 && cyc < 70000) begin
            step();
            cyc++;
        end
        check_eq("t7_sat_drained", 32'(rem[0]), 32'd0);
        @(negedge BUS_CLK);
        check_eq("t7_saturated", 32'(STAT_COUNT[15:0]), 32'h0000FFFF);
        sb_en = 1'b1;
`endif

        check_eq("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
